// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types and constants for spi_controller (optional SPI_CONTROLLER_READ_EN)
package spi_ctrl_pkg;

  localparam int   FRAME_BITS       = 16;
  localparam logic RW_WRITE         = 1'b1;
  localparam int   HALF_PERIOD_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_clk_tick.sv
// rtl/spi_clk_tick.sv - one-cycle tick every HALF_PERIOD enabled clocks
module spi_clk_tick #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // next count: restart on clear, wrap after each tick, park at 0 while disabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = 8'd0;
    end else if (tick_o) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 register-write frame controller (SPI_CONTROLLER_READ_EN adds readback)
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
`ifdef SPI_CONTROLLER_READ_EN
  input  logic       rw,
  input  logic       cipo,
  output logic [7:0] rdata,
`endif
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic                    phase_q, phase_d;   // SHIFT: 0 = sclk high half, 1 = low half; GAP: half index
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    done_q, done_d;
  logic                    tick;
  logic                    accept;
  logic                    rw_bit;

`ifdef SPI_CONTROLLER_READ_EN
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdata_q, rdata_d;
  assign rw_bit = rw;
  assign rdata  = rdata_q;
`else
  assign rw_bit = RW_WRITE;
`endif

  assign accept = start && (state_q == ST_IDLE) && !rst;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign sclk   = (state_q == ST_SHIFT) && !phase_q;
  assign ncs    = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
  assign copi   = busy && shreg_q[FRAME_BITS-1];

  spi_clk_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (busy),
    .clr_i  (accept),
    .tick_o (tick)
  );

  // frame sequencing: shift on sclk fall, count bits at end of each low half
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
`ifdef SPI_CONTROLLER_READ_EN
    rx_d      = rx_q;
    rdata_d   = rdata_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          shreg_d   = {rw_bit, addr, wdata};
          bit_cnt_d = 4'd0;
          phase_d   = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          phase_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end else if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_HOLD;
            phase_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            phase_d   = 1'b0;
`ifdef SPI_CONTROLLER_READ_EN
            // rising edge of bits 7..0 (next bit index 8..15)
            if (bit_cnt_q >= 4'd7) begin
              rx_d = {rx_q[6:0], cipo};
            end
`endif
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          phase_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (phase_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
            rdata_d = rx_q;
`endif
          end else begin
            phase_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      bit_cnt_q <= 4'd0;
      shreg_q   <= '0;
      done_q    <= 1'b0;
`ifdef SPI_CONTROLLER_READ_EN
      rx_q      <= 8'd0;
      rdata_q   <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      done_q    <= done_d;
`ifdef SPI_CONTROLLER_READ_EN
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed self-checking bench for spi_controller (SPI_CONTROLLER_READ_EN aware)
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic       sclk, copi, ncs, busy, done;
`ifdef SPI_CONTROLLER_READ_EN
  logic       rw = 1'b1;
  logic       cipo;
  logic [7:0] rdata;
  logic [15:0] resp_word = 16'h0000;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_controller #(.HALF_PERIOD(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .addr  (addr),
    .wdata (wdata),
`ifdef SPI_CONTROLLER_READ_EN
    .rw    (rw),
    .cipo  (cipo),
    .rdata (rdata),
`endif
    .sclk  (sclk),
    .copi  (copi),
    .ncs   (ncs),
    .busy  (busy),
    .done  (done)
  );

  // responder/monitor state
  logic [15:0] cap = 16'd0;
  int          ec = 0;
  int          ncs_bad = 0;
  int          glitch = 0;
  int          done_cnt = 0;
  int          hi_run = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_copi = 1'b0;
  logic        prev_ncs = 1'b1;
  logic [15:0] frames_q[$];
  int          edges_q[$];
  int          gap_q[$];

  // bus monitor: responder capture of copi on sclk rise, frame/gap logging on ncs edges
  always @(negedge clk) begin
    if (prev_sclk === 1'b0 && sclk === 1'b1) begin
      cap <= {cap[14:0], copi};
      ec  <= ec + 1;
      if (ncs !== 1'b0) ncs_bad <= ncs_bad + 1;
    end
    if (prev_sclk === 1'b1 && sclk === 1'b1 && copi !== prev_copi) glitch <= glitch + 1;
    if (prev_ncs === 1'b1 && ncs === 1'b0) begin
      gap_q.push_back(hi_run);
      ec <= 0;
    end
    if (prev_ncs === 1'b0 && ncs === 1'b1) begin
      frames_q.push_back(cap);
      edges_q.push_back(ec);
    end
    if (ncs === 1'b1) hi_run <= hi_run + 1;
    else hi_run <= 0;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    prev_sclk <= sclk;
    prev_copi <= copi;
    prev_ncs  <= ncs;
  end

`ifdef SPI_CONTROLLER_READ_EN
  int   r_falls = 0;
  logic r_prev_sclk = 1'b0;
  // responder data out: bit j of resp_word (MSB first) presented after j sclk falls
  always @(negedge clk) begin
    if (ncs !== 1'b0) begin
      r_falls <= 0;
      cipo    <= resp_word[15];
    end else if (r_prev_sclk === 1'b1 && sclk === 1'b0) begin
      r_falls <= r_falls + 1;
      if (r_falls < 15) cipo <= resp_word[4'(14 - r_falls)];
    end
    r_prev_sclk <= sclk;
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; pulses start across the following posedge
  task automatic do_start(input logic [6:0] a, input logic [7:0] d);
    start = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  int cyc;
  int d_snap;

  initial begin
    // reset with a coincident start
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ncs", 32'(ncs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_copi", 32'(copi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef SPI_CONTROLLER_READ_EN
    check("rst_rdata", 32'(rdata), 32'h00);
`endif
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_in_rst_ignored", 32'(busy), 32'd0);

    // frame 0: addr 0x00 wdata 0xFF
    @(negedge clk);
    settle();
    d_snap = done_cnt;
    @(negedge clk);
    do_start(7'h00, 8'hFF);
    check("f0_busy_first", 32'(busy), 32'd1);
    wait_done(cyc);
    check("f0_busy_cycles", 32'(cyc), 32'd144);
    check("f0_busy_low_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("f0_done_one_cycle", 32'(done), 32'd0);
    settle();
    check("f0_frame", 32'(frames_q[0]), 32'h80FF);
    check("f0_edges", 32'(edges_q[0]), 32'd16);
    check("f0_done_count", 32'(done_cnt - d_snap), 32'd1);

    // frame 1: addr 0x04 wdata 0xA5, inputs change and start retried mid-frame
    d_snap = done_cnt;
    @(negedge clk);
    do_start(7'h04, 8'hA5);
    addr  = 7'h7F;
    wdata = 8'h00;
    repeat (9) @(negedge clk);
    do_start(7'h7F, 8'h00);
    wait_done(cyc);
    check("f1_done_seen", 32'(done), 32'd1);
    repeat (30) @(negedge clk);
    check("f1_idle_after", 32'(busy), 32'd0);
    settle();
    check("f1_frame", 32'(frames_q[1]), 32'h84A5);
    check("f1_edges", 32'(edges_q[1]), 32'd16);
    check("f1_frame_count", 32'(frames_q.size()), 32'd2);
    check("f1_done_count", 32'(done_cnt - d_snap), 32'd1);
    check("ncs_low_at_all_rises", 32'(ncs_bad), 32'd0);

    // reset on the 50th busy cycle
    d_snap = done_cnt;
    @(negedge clk);
    do_start(7'h12, 8'h34);
    repeat (49) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ncs", 32'(ncs), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    settle();
    check("abort_no_done", 32'(done_cnt - d_snap), 32'd0);

    // full frame after abort
    @(negedge clk);
    do_start(7'h55, 8'h3C);
    wait_done(cyc);
    check("f3_busy_cycles", 32'(cyc), 32'd144);
    settle();
    check("f3_frame", 32'(frames_q[3]), 32'hD53C);
    check("f3_edges", 32'(edges_q[3]), 32'd16);

    // back-to-back: second start on the done cycle
    repeat (5) @(negedge clk);
    do_start(7'h2A, 8'h5A);
    wait_done(cyc);
    check("b2b_done_seen", 32'(done), 32'd1);
    do_start(7'h11, 8'hEE);
    check("b2b_accepted", 32'(busy), 32'd1);
    wait_done(cyc);
    check("b2b_second_cycles", 32'(cyc), 32'd144);
    settle();
    check("b2b_frame_a", 32'(frames_q[4]), 32'hAA5A);
    check("b2b_frame_b", 32'(frames_q[5]), 32'h91EE);
    check("b2b_edges_b", 32'(edges_q[5]), 32'd16);
    check("b2b_gap_ge_8", 32'(gap_q[5] >= 8), 32'd1);

`ifdef SPI_CONTROLLER_READ_EN
    // read frame: rw=0, responder returns 0x3C in bits 7..0
    check("rdata_before_read", 32'(rdata), 32'h00);
    resp_word = 16'h003C;
    rw = 1'b0;
    repeat (5) @(negedge clk);
    do_start(7'h10, 8'h00);
    rw = 1'b1;
    wait_done(cyc);
    check("rd_done_seen", 32'(done), 32'd1);
    check("rd_rdata_at_done", 32'(rdata), 32'h3C);
    repeat (10) @(negedge clk);
    check("rd_rdata_hold", 32'(rdata), 32'h3C);
    settle();
    check("rd_frame", 32'(frames_q[6]), 32'h1000);
`endif

    check("copi_stable_while_sclk_high", 32'(glitch), 32'd0);
    check("ncs_low_at_all_rises_end", 32'(ncs_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter: HALF_PERIOD, 4, clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  one-cycle request to issue a frame.
REQ-005 SHALL have port: addr  input  7  target register address.
REQ-006 SHALL have port: wdata  input  8  register write data.
REQ-007 SHALL have port: sclk  output  1  SPI clock, mode 0 (idle low).
REQ-008 SHALL have port: copi  output  1  controller-out serial data, MSB first.
REQ-009 SHALL have port: ncs  output  1  chip select, active-low.
REQ-010 SHALL have port: busy  output  1  frame in progress.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL transmit 16-bit frames: bit15 = R/W (1 = write), bits14:8 = addr, bits7:0 = wdata.
REQ-013 SHALL accept start only in IDLE (busy=0); start while busy SHALL be ignored, with no queuing.
REQ-014 SHALL latch addr/wdata on the accept cycle; later input changes SHALL NOT affect the frame in flight.
REQ-015 SHALL use FSM states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-016 SETUP: from the cycle after accept, ncs=0, sclk=0, copi=bit15, lasting HALF_PERIOD cycles.
REQ-017 SHIFT: per bit, sclk high HALF_PERIOD cycles then low HALF_PERIOD cycles; copi SHALL change only on the cycle sclk falls, holding stable across every rising edge.
REQ-018 SHIFT SHALL end after the 16th falling edge; the 4-bit bit counter SHALL NOT wrap into a 17th bit.
REQ-019 HOLD: ncs=0, sclk=0 for HALF_PERIOD cycles; ncs then SHALL rise.
REQ-020 GAP: ncs=1 for 2*HALF_PERIOD cycles, enforcing the minimum inter-frame idle time.
REQ-021 busy SHALL be high for exactly 36*HALF_PERIOD cycles per frame, starting the cycle after accept.
REQ-022 done SHALL pulse for one cycle on the first cycle busy is low after a frame; start on that same cycle SHALL be accepted.
REQ-023 In IDLE: sclk=0, copi=0, ncs=1.

Reset
REQ-024 While rst=1: state=IDLE; sclk=0, copi=0, ncs=1, busy=0, done=0; counters and shift register cleared.
REQ-025 rst mid-frame SHALL abort the frame on the next edge, with no done pulse.
REQ-026 start coincident with rst SHALL be ignored.

Configuration
REQ-027 Macro SPI_CONTROLLER_READ_EN, when defined, SHALL add these ports: rw input 1, cipo input 1, rdata output 8.
REQ-028 With SPI_CONTROLLER_READ_EN defined:
- bit15 SHALL be the latched rw.
- cipo SHALL be sampled on the rising SCLK edges of bits 7..0.
- rdata SHALL update when done pulses and hold until the next done.
- rdata SHALL be 0 after reset.
REQ-029 Without SPI_CONTROLLER_READ_EN: bit15 SHALL be constant 1, and the rw/cipo/rdata ports SHALL be absent.

Structure
REQ-030 Package spi_ctrl_pkg SHALL hold: the FSM state enum; FRAME_BITS=16; RW_WRITE=1; the HALF_PERIOD default.
REQ-031 Sub-module spi_clk_tick SHALL generate a one-cycle tick every HALF_PERIOD cycles.
- Enable is busy.
- It SHALL restart at 0 on accept.

Verification
REQ-032 HALF_PERIOD=4, start with addr=0x00, wdata=0xFF -> copi bit sequence 1000_0000_1111_1111; busy high for 144 cycles; one done pulse.
REQ-033 addr=0x04, wdata=0xA5; a responder model sampling copi on sclk rising edges -> it captures 0x84A5 after 16 edges, and ncs stays low throughout.
REQ-034 start pulsed again 10 cycles after accept -> ignored: exactly one frame, one done pulse.
REQ-035 rst asserted on the 50th busy cycle -> next cycle: ncs=1, sclk=0, busy=0; no done pulse; a subsequent start produces a full, correct frame.
REQ-036 start on the done cycle, two back-to-back frames -> ncs high for at least 8 cycles between them; both frames are bit-correct.
REQ-037 SPI_CONTROLLER_READ_EN defined, rw=0, cipo driven 0x3C during bits 7..0 -> bit15=0 on copi; rdata=0x3C when done pulses.
